mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store unit that drives the word-wide, word-addressed data memory (clk, regWE, Addr, DataIn, DataOut).
- Accepts one byte, halfword or word load/store at a time from the CPU datapath and converts the byte address to a word index.
- Performs read-modify-write for sub-word stores and sign/zero-extends sub-word loads.
- Returns a one-cycle response pulse to the CPU.

Parameters:
- MEM_READ_LATENCY, 1: cycles from the memory address being driven until the data output is valid. Allowed values are 1 to 4.
- ADDR_WIDTH, 32: CPU byte-address width. The memory word index is req_addr[ADDR_WIDTH-1:2], zero-extended to 32 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle; a request is accepted when req_valid and req_ready are both high at a rising edge
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_signed  in  1  sign-extend a sub-word load
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, taken from the low bytes
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal request, qualified by resp_valid
- mem_addr  out  32  word index to memory Addr
- mem_we  out  1  to memory regWE
- mem_din  out  32  to memory DataIn
- mem_dout  in  32  from memory DataOut

Behaviour:
- Reset and clock: synchronous reset is sampled on the rising edge of clk.
- Reset values:
  - state is IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
  - mem_we=0, mem_addr=0, mem_din=0.
- Request capture: address, size, signed flag, write flag and write data are registered on acceptance. Request inputs are ignored outside IDLE.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE, on acceptance:
    - Illegal or misaligned request goes to RESP. This covers size=11, half with addr[0]=1, and word with addr[1:0]!=0.
    - Word store goes to WR.
    - Any load or sub-word store goes to RD.
  - RD: drives mem_addr with mem_we=0 and holds for MEM_READ_LATENCY cycles using a down-counter. In the last RD cycle, mem_dout is captured.
    - A load then goes to RESP.
    - A sub-word store then goes to WR.
  - WR: lasts exactly one cycle. mem_we=1 and mem_din holds either the word data or the merged word. The memory write occurs at the edge that ends WR. Next state is RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE. req_ready is 0 in RD, WR and RESP.
- Lane rules (little-endian):
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Half lane = addr[1]. It occupies bits [15:0] when addr[1]=0 and bits [31:16] when addr[1]=1.
  - Loads extract the lane and extend it to 32 bits, using the sign bit if req_signed=1 and zero-fill otherwise. Word loads pass through unchanged.
  - A store merge replaces only the target lane in the captured word.
- Latency, counted from the acceptance cycle as cycle 0:
  - Error: resp_valid in cycle 1, and the memory is not touched (mem_we stays 0).
  - Word store: WR in cycle 1, resp_valid in cycle 2.
  - Load: RD in cycles 1..L, resp_valid in cycle L+1.
  - Sub-word store: RD in cycles 1..L, WR in cycle L+1, resp_valid in cycle L+2.
  - L = MEM_READ_LATENCY.
- Back-to-back requests: a new request can be accepted in the cycle after RESP. There is no bubble beyond the RESP cycle.
- Reset mid-operation:
  - mem_we is combinationally gated by ~reset, so a WR cycle coinciding with reset writes nothing.
  - The next state is IDLE, and any pending response is dropped with no resp_valid.
- Output stability: mem_addr and mem_din are registered and stable throughout RD and WR.

Decomposition:
- Package mem_access_pkg holds:
  - SIZE_BYTE, SIZE_HALF, SIZE_WORD and SIZE_ILLEGAL encodings;
  - the state encoding for IDLE, RD, WR and RESP;
  - a misalignment check function.
- Sub-module mem_lane_align is combinational. Inputs are the word, the lane address, size and signed flag. Outputs are the extracted load value and the merged store word. mem_access_unit owns the FSM, the counter and the registers.

Test Plan:
Bench memory model is word-addressed, holds 64 words, and has MEM_READ_LATENCY=1 unless noted.
- Word store then load: store word 0xDEADBEEF to byte address 0x0C, then load a word from 0x0C. The store writes word index 3 with mem_we high for exactly one cycle and resp_valid in cycle 2; the load returns resp_rdata=0xDEADBEEF in cycle 2.
- Byte store RMW: word 3 holds 0x11223344; store byte 0xAA to byte address 0x0D. Word 3 becomes 0x1122AA44 and resp_valid arrives in cycle 3.
- Signed byte load: load byte from 0x0D with req_signed=1 returns 0xFFFFFFAA; with req_signed=0 it returns 0x000000AA.
- Halfword load: word 1 holds 0x8001C0DE; load a half from byte address 0x06, signed, and expect 0xFFFF8001.
- Misaligned and illegal: a word load at 0x0E, a half store at 0x05 and size=11 each produce resp_err=1, resp_rdata=0 and resp_valid in cycle 1, with mem_we never asserted.
- Reset in WR: assert reset during the WR cycle of a word store of 0x5 to 0x04. The memory keeps its old value, there is no resp_valid, and req_ready=1 in the next cycle. Rerun with MEM_READ_LATENCY=3 and check that the sub-word store response arrives in cycle 5.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size/state encodings and alignment check shared by the load/store unit
package mem_access_pkg;
  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;
  function automatic logic misaligned(size_e size, logic [1:0] lane);
    return size == SIZE_ILLEGAL || (size == SIZE_HALF && lane[0]) || (size == SIZE_WORD && lane != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU request/response and word-memory port bundle; slave = unit side, master = environment side
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic [31:0]           mem_addr;
  logic                  mem_we;
  logic [31:0]           mem_din;
  logic [31:0]           mem_dout;
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_din
  );
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extract with sign/zero extension (ld) and sub-word store merge (merged)
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] ld,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [31:0] mask;
  logic [31:0] lanes;
  always_comb begin
    sh = size == SIZE_HALF ? {lane[1], 4'b0000} : {lane, 3'b000};
    mask = size == SIZE_BYTE ? 32'h0000_00ff : size == SIZE_HALF ? 32'h0000_ffff : 32'hffff_ffff;
    lanes = word >> sh;
    ld = size == SIZE_BYTE ? {{24{sgn & lanes[7]}}, lanes[7:0]} :
         size == SIZE_HALF ? {{16{sgn & lanes[15]}}, lanes[15:0]} : word;
    merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit with RMW for sub-word stores (clk, reset, bus: req/resp + word memory port)
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_READ_LATENCY = 1,
  parameter int ADDR_WIDTH       = 32
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);
  state_e                state, nxt;
  logic [2:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr;
  size_e                 size;
  logic                  sgn, wr, err, accept, last;
  logic [31:0]           wdata, rdata, ld, merged, maddr, din;
  assign accept = bus.req_valid && state == IDLE;
  assign last = state == RD && cnt == 3'd0;
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_err = state == RESP && err;
  assign bus.resp_rdata = state == RESP ? rdata : 32'd0;
  assign bus.mem_we = state == WR && !reset;
  assign bus.mem_addr = maddr;
  assign bus.mem_din = din;
  mem_lane_align u_align (
    .word  (bus.mem_dout),
    .lane  (addr[1:0]),
    .size  (size),
    .sgn   (sgn),
    .wdata (wdata),
    .ld    (ld),
    .merged(merged)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !accept ? IDLE :
                  misaligned(size_e'(bus.req_size), bus.req_addr[1:0]) ? RESP :
                  bus.req_write && bus.req_size == SIZE_WORD ? WR : RD;
      RD:   nxt = !last ? RD : wr ? WR : RESP;
      WR:   nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  // mem_din starts as the raw store word; a sub-word store replaces it with the merged word in its last RD cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 3'd0;
      addr <= '0;
      size <= SIZE_BYTE;
      sgn <= 1'b0;
      wr <= 1'b0;
      err <= 1'b0;
      wdata <= 32'd0;
      rdata <= 32'd0;
      maddr <= 32'd0;
      din <= 32'd0;
    end else begin
      if (accept) begin
        addr <= bus.req_addr;
        size <= size_e'(bus.req_size);
        sgn <= bus.req_signed;
        wr <= bus.req_write;
        err <= misaligned(size_e'(bus.req_size), bus.req_addr[1:0]);
        wdata <= bus.req_wdata;
        rdata <= 32'd0;
        cnt <= 3'(MEM_READ_LATENCY - 1);
        maddr <= 32'(bus.req_addr[ADDR_WIDTH-1:2]);
        din <= bus.req_wdata;
      end
      if (state == RD) cnt <= cnt - 3'd1;
      if (last) begin
        din <= merged;
        rdata <= wr ? 32'd0 : ld;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors against a 64-word memory model, latency 1 (u0) and latency 3 (u1)
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        rw = 1'b0, rsgn = 1'b0;
  logic [1:0]  rsize = 2'b00;
  logic [31:0] raddr = 32'd0, rwdata = 32'd0;
  logic        sel = 1'b0;
  int          cmp = 0, fail = 0;
  int          we0 = 0, we1 = 0;
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  logic [31:0] p0 = 32'd0, p1 = 32'd0;
  always #5 clk = ~clk;
  mem_access_unit_if #(.ADDR_WIDTH(32)) if0 ();
  mem_access_unit_if #(.ADDR_WIDTH(32)) if1 ();
  mem_access_unit #(.MEM_READ_LATENCY(1), .ADDR_WIDTH(32)) u0 (.clk(clk), .reset(reset), .bus(if0));
  mem_access_unit #(.MEM_READ_LATENCY(3), .ADDR_WIDTH(32)) u1 (.clk(clk), .reset(reset), .bus(if1));
  assign if0.req_valid = valid0;
  assign if1.req_valid = valid1;
  assign if0.req_write = rw;
  assign if1.req_write = rw;
  assign if0.req_size = rsize;
  assign if1.req_size = rsize;
  assign if0.req_signed = rsgn;
  assign if1.req_signed = rsgn;
  assign if0.req_addr = raddr;
  assign if1.req_addr = raddr;
  assign if0.req_wdata = rwdata;
  assign if1.req_wdata = rwdata;
  assign if0.mem_dout = mem0[if0.mem_addr[5:0]];
  assign if1.mem_dout = p1;
  always @(posedge clk) begin
    if (if0.mem_we) begin
      mem0[if0.mem_addr[5:0]] <= if0.mem_din;
      we0 <= we0 + 1;
    end
    if (if1.mem_we) begin
      mem1[if1.mem_addr[5:0]] <= if1.mem_din;
      we1 <= we1 + 1;
    end
    p0 <= mem1[if1.mem_addr[5:0]];
    p1 <= p0;
  end
  wire        rv  = sel ? if1.resp_valid : if0.resp_valid;
  wire        rdy = sel ? if1.req_ready : if0.req_ready;
  wire        rer = sel ? if1.resp_err : if0.resp_err;
  wire [31:0] rrd = sel ? if1.resp_rdata : if0.resp_rdata;
  wire [31:0] wec = sel ? we1 : we0;
  typedef struct {
    logic        w;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
    int          exp_we;
  } vec_t;
  vec_t vecs [19];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_req(input logic s, input logic w, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_cyc, input int exp_we, input string tag);
    int          cyc;
    int          we_start;
    logic [31:0] rd;
    logic        er;
    cyc = 0;
    rd = 32'd0;
    er = 1'b0;
    sel = s;
    @(negedge clk);
    chk({tag, " ready"}, 32'(rdy), 32'd1);
    rw = w;
    rsize = size;
    rsgn = sgn;
    raddr = addr;
    rwdata = wdata;
    we_start = int'(wec);
    if (s) valid1 = 1'b1;
    else valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    valid1 = 1'b0;
    for (int n = 1; n <= 20 && cyc == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (rv) begin
        cyc = n;
        rd = rrd;
        er = rer;
      end
    end
    if (cyc == 0) begin
      cmp++;
      fail++;
      $display("FAIL %s timeout: no resp_valid within 20 cycles", tag);
    end else begin
      chk({tag, " cycle"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, " rdata"}, rd, exp_rdata);
      chk({tag, " err"}, 32'(er), 32'(exp_err));
      @(negedge clk);
      chk({tag, " pulse"}, 32'(rv), 32'd0);
      chk({tag, " ready_after"}, 32'(rdy), 32'd1);
      chk({tag, " we_count"}, 32'(int'(wec) - we_start), 32'(exp_we));
    end
  endtask
  initial begin
    logic        saw_rv;
    int          we_start;
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h0C, 32'h11223344, 32'h0, 1'b0, 2, 1};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h0D, 32'h000000AA, 32'h0, 1'b0, 3, 1};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h1122AA44, 1'b0, 2, 0};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 32'h000000AA, 1'b0, 2, 0};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h04, 32'h8001C0DE, 32'h0, 1'b0, 2, 1};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h06, 32'h0, 32'hFFFF8001, 1'b0, 2, 0};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h04, 32'h0, 32'h0000C0DE, 1'b0, 2, 0};
    vecs[10] = '{1'b0, 2'b01, 1'b1, 32'h04, 32'h0, 32'hFFFFC0DE, 1'b0, 2, 0};
    vecs[11] = '{1'b0, 2'b00, 1'b1, 32'h07, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 32'h0, 1'b1, 1, 0};
    vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h05, 32'h1234, 32'h0, 1'b1, 1, 0};
    vecs[14] = '{1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0};
    vecs[15] = '{1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000BEEF, 32'h0, 1'b0, 3, 1};
    vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hBEEFAA44, 1'b0, 2, 0};
    vecs[17] = '{1'b1, 2'b00, 1'b0, 32'h0C, 32'h00001234, 32'h0, 1'b0, 3, 1};
    vecs[18] = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hBEEFAA34, 1'b0, 2, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 32'(if0.req_ready), 32'd1);
    chk("rst resp_valid", 32'(if0.resp_valid), 32'd0);
    chk("rst resp_err", 32'(if0.resp_err), 32'd0);
    chk("rst resp_rdata", if0.resp_rdata, 32'd0);
    chk("rst mem_we", 32'(if0.mem_we), 32'd0);
    chk("rst mem_addr", if0.mem_addr, 32'd0);
    chk("rst mem_din", if0.mem_din, 32'd0);
    chk("rst ready L3", 32'(if1.req_ready), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 19; i++)
      do_req(1'b0, vecs[i].w, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_cyc, vecs[i].exp_we, $sformatf("v%0d", i));
    chk("mem word3", mem0[3], 32'hBEEFAA34);
    sel = 1'b0;
    @(negedge clk);
    rw = 1'b1;
    rsize = 2'b10;
    rsgn = 1'b0;
    raddr = 32'h04;
    rwdata = 32'h5;
    we_start = we0;
    valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    chk("wr state we", 32'(if0.mem_we), 32'd1);
    chk("wr state din", if0.mem_din, 32'h5);
    chk("wr state addr", if0.mem_addr, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_wr we gated", 32'(if0.mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wr ready", 32'(if0.req_ready), 32'd1);
    saw_rv = if0.resp_valid;
    repeat (3) begin
      @(negedge clk);
      saw_rv = saw_rv | if0.resp_valid;
    end
    chk("rst_wr no resp", 32'(saw_rv), 32'd0);
    chk("rst_wr no write", 32'(we0 - we_start), 32'd0);
    chk("rst_wr mem kept", mem0[1], 32'h8001C0DE);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h8001C0DE, 1'b0, 2, 0, "rst_wr reload");
    do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, 32'h0, 1'b0, 2, 1, "L3 word st");
    do_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h0A, 32'h00000055, 32'h0, 1'b0, 5, 1, "L3 byte st");
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h11553344, 1'b0, 4, 0, "L3 word ld");
    do_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 32'h00001155, 1'b0, 4, 0, "L3 half ld");
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h09, 32'h0, 32'h0, 1'b1, 1, 0, "L3 misaligned");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
    $finish;
  end
endmodule
